// File: rtl/red_pitaya_hk_gpio.sv
// red_pitaya_hk_gpio
//   Housekeeping GPIO block: NB banks of DW bidirectional pins with direction,
//   output, synchronised/filtered input, per-pin rise/fall edge capture into
//   sticky write-1-to-clear STATUS, per-bank interrupt enables, a LED register
//   and a single registered level interrupt.
//
//   Optional build macro: HK_GPIO_DEBOUNCE_EN adds a per-pin debounce counter
//   between the synchroniser and the filtered input. Without it the filter is
//   a plain register stage and DBC_LEN reads as zero.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   gpio_i               pad input, bank b at [b*DW +: DW]
//   gpio_o, gpio_dir_o   pad output data and output enable (1 = drive)
//   led_o                LED drive
//   irq_o                level interrupt (OR of all pending enabled status)
//   sys_*                system bus: addr/wdata/wen/ren in, rdata/err/ack out
//
// Register fields are at most 32 bits wide (DW, DWL, DBC_W <= 32).
module red_pitaya_hk_gpio #(
  parameter int NB    = 2,
  parameter int DW    = 8,
  parameter int DWL   = 8,
  parameter int DBC_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NB*DW-1:0]  gpio_i,
  output logic [NB*DW-1:0]  gpio_o,
  output logic [NB*DW-1:0]  gpio_dir_o,
  output logic [DWL-1:0]    led_o,
  output logic              irq_o,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam int NP = NB * DW;

  logic [NP-1:0]    dir_r, out_r, rise_en_r, fall_en_r, status_r, irq_en_r;
  logic [DWL-1:0]   led_r;
  logic [NP-1:0]    sync1_r, sync2_r, filt_r, filt_d_r;
  logic             irq_r, ack_r, err_r;
  logic [31:0]      rdata_r;

  logic [NB-1:0]    bank_hit_s;
  logic             bank_area_s, glob_hit_s, mapped_s;
  logic [2:0]       off_s;
  logic [NP-1:0]    w1c_s, rise_s, fall_s;
  logic [NB-1:0]    pend_s;
  logic [DW-1:0]    fld_s;
  logic [31:0]      rd_bank_s, rd_glob_s, rd_val_s;
  logic [DBC_W-1:0] dbc_len_s;
  logic             unused_s;

  assign off_s    = sys_addr[4:2];
  assign rise_s   = filt_r & ~filt_d_r;
  assign fall_s   = ~filt_r & filt_d_r;
  assign unused_s = ^{sys_addr[31:20], sys_wdata};

  // Address decode: bank window below 0x100 (offset 0x1C is a hole), globals at 0x100-0x10C
  always_comb begin
    bank_area_s = (sys_addr[19:8] == 12'h000) && (sys_addr[1:0] == 2'b00) && (off_s != 3'd7);
    bank_hit_s  = {NB{1'b0}};
    for (int b = 0; b < NB; b++) begin
      bank_hit_s[b] = bank_area_s && (sys_addr[7:5] == 3'(b));
    end
    glob_hit_s = (sys_addr[19:4] == 16'h0010) && (sys_addr[1:0] == 2'b00);
    mapped_s   = (|bank_hit_s) || glob_hit_s;
  end

  // Per-bank W1C mask and pending reduction
  always_comb begin
    w1c_s  = {NP{1'b0}};
    pend_s = {NB{1'b0}};
    for (int b = 0; b < NB; b++) begin
      w1c_s[b*DW +: DW] = (sys_wen && bank_hit_s[b] && (off_s == 3'd5)) ? sys_wdata[DW-1:0] : {DW{1'b0}};
      pend_s[b]         = |(status_r[b*DW +: DW] & irq_en_r[b*DW +: DW]);
    end
  end

  // Read data mux; unmapped addresses fall through to zero
  always_comb begin
    rd_bank_s = 32'd0;
    fld_s     = {DW{1'b0}};
    for (int b = 0; b < NB; b++) begin
      case (off_s)
        3'd0:    fld_s = dir_r[b*DW +: DW];
        3'd1:    fld_s = out_r[b*DW +: DW];
        3'd2:    fld_s = filt_r[b*DW +: DW];
        3'd3:    fld_s = rise_en_r[b*DW +: DW];
        3'd4:    fld_s = fall_en_r[b*DW +: DW];
        3'd5:    fld_s = status_r[b*DW +: DW];
        3'd6:    fld_s = irq_en_r[b*DW +: DW];
        default: fld_s = {DW{1'b0}};
      endcase
      rd_bank_s = bank_hit_s[b] ? 32'(fld_s) : rd_bank_s;
    end
    case (sys_addr[3:2])
      2'd0:    rd_glob_s = {8'h00, 8'(DWL), 8'(NB), 8'(DW)};
      2'd1:    rd_glob_s = 32'(led_r);
      2'd2:    rd_glob_s = 32'(dbc_len_s);
      2'd3:    rd_glob_s = 32'(pend_s);
      default: rd_glob_s = 32'd0;
    endcase
    rd_val_s = glob_hit_s ? rd_glob_s : rd_bank_s;
  end

  // Bus response: one ack per strobe; read data sampled before any same-cycle write lands
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r   <= sys_wen | sys_ren;
      err_r   <= (sys_wen | sys_ren) & ~mapped_s;
      rdata_r <= sys_ren ? rd_val_s : 32'd0;
    end
  end

  // Control registers, sticky status (set beats same-cycle clear) and interrupt
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dir_r     <= {NP{1'b0}};
      out_r     <= {NP{1'b0}};
      rise_en_r <= {NP{1'b0}};
      fall_en_r <= {NP{1'b0}};
      irq_en_r  <= {NP{1'b0}};
      status_r  <= {NP{1'b0}};
      led_r     <= {DWL{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (sys_wen && bank_hit_s[b]) begin
          case (off_s)
            3'd0:    dir_r[b*DW +: DW]     <= sys_wdata[DW-1:0];
            3'd1:    out_r[b*DW +: DW]     <= sys_wdata[DW-1:0];
            3'd3:    rise_en_r[b*DW +: DW] <= sys_wdata[DW-1:0];
            3'd4:    fall_en_r[b*DW +: DW] <= sys_wdata[DW-1:0];
            3'd6:    irq_en_r[b*DW +: DW]  <= sys_wdata[DW-1:0];
            default: ;
          endcase
        end
      end
      if (sys_wen && glob_hit_s && (sys_addr[3:2] == 2'd1)) begin
        led_r <= sys_wdata[DWL-1:0];
      end
      status_r <= (status_r & ~w1c_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
      irq_r    <= |pend_s;
    end
  end

  // Two-flop synchroniser and one-cycle delayed copy of the filtered input
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_r  <= {NP{1'b0}};
      sync2_r  <= {NP{1'b0}};
      filt_d_r <= {NP{1'b0}};
    end else begin
      sync1_r  <= gpio_i;
      sync2_r  <= sync1_r;
      filt_d_r <= filt_r;
    end
  end

`ifdef HK_GPIO_DEBOUNCE_EN
  logic [DBC_W-1:0]         dbc_len_r;
  logic [NP-1:0][DBC_W-1:0] cnt_r;

  assign dbc_len_s = dbc_len_r;

  // Debounce: count while sync disagrees with filt; adopt sync once the count reaches DBC_LEN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dbc_len_r <= {DBC_W{1'b0}};
      cnt_r     <= {(NP*DBC_W){1'b0}};
      filt_r    <= {NP{1'b0}};
    end else begin
      if (sys_wen && glob_hit_s && (sys_addr[3:2] == 2'd2)) begin
        dbc_len_r <= sys_wdata[DBC_W-1:0];
      end
      for (int i = 0; i < NP; i++) begin
        if (sync2_r[i] != filt_r[i]) begin
          if (cnt_r[i] >= dbc_len_r) begin
            filt_r[i] <= sync2_r[i];
            cnt_r[i]  <= {DBC_W{1'b0}};
          end else if (cnt_r[i] != {DBC_W{1'b1}}) begin
            cnt_r[i] <= cnt_r[i] + {{(DBC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_r[i] <= {DBC_W{1'b0}};
        end
      end
    end
  end
`else
  assign dbc_len_s = {DBC_W{1'b0}};

  // Filter stage without debounce: plain register copy of the synchroniser
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      filt_r <= {NP{1'b0}};
    end else begin
      filt_r <= sync2_r;
    end
  end
`endif

  assign gpio_o     = out_r;
  assign gpio_dir_o = dir_r;
  assign led_o      = led_r;
  assign irq_o      = irq_r;
  assign sys_ack    = ack_r;
  assign sys_err    = err_r;
  assign sys_rdata  = rdata_r;

endmodule
